// File: rtl/composer_control_if.sv
// Bundle between the composer sequencer and its datapath/PS2 front end.
// master = sequencer side (drives mode enables), slave = datapath side.
interface composer_control_if #(
   parameter int CW = 5
);
   logic [7:0]    received_data;
   logic          received_data_en;
   logic          score_drawn;
   logic          is_full;
   logic          insert_delay_done;
   logic          play_done;
   logic          menu_enable;
   logic          list_enable;
   logic          song_list_enable;
   logic          draw_score;
   logic          note_enable;
   logic          InsertEnable;
   logic          deleteEnable;
   logic          playEnable;
   logic          end_vga_display;
   logic [2:0]    note_code;
   logic [CW-1:0] note_count;
   logic [3:0]    state;

   modport master (
      input  received_data, received_data_en, score_drawn, is_full,
             insert_delay_done, play_done,
      output menu_enable, list_enable, song_list_enable, draw_score,
             note_enable, InsertEnable, deleteEnable, playEnable,
             end_vga_display, note_code, note_count, state
   );

   modport slave (
      output received_data, received_data_en, score_drawn, is_full,
             insert_delay_done, play_done,
      input  menu_enable, list_enable, song_list_enable, draw_score,
             note_enable, InsertEnable, deleteEnable, playEnable,
             end_vga_display, note_code, note_count, state
   );
endinterface

// File: rtl/composer_control.sv
// Composer top-level sequencer: PS/2 key decode, mode FSM with registered
// one-hot mode enables, note counter and latched insert note.
module composer_control #(
   parameter int MAX_NOTES = 16,
   parameter int CW        = 5
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   composer_control_if.master bus
);
   typedef enum logic [3:0] {
      S_MENU = 4'd0, S_LIST = 4'd1, S_SONGS = 4'd2, S_SCORE = 4'd3,
      S_NOTE_WAIT = 4'd4, S_INSERT = 4'd5, S_DELETE = 4'd6, S_PLAY = 4'd7,
      S_END = 4'd8
   } state_t;

   localparam logic [CW-1:0] LP_MAX = CW'(MAX_NOTES);

   state_t        r_state, w_next_state;
   logic [8:0]    r_en, w_en_next;
   logic          r_brk, w_brk_next;
   logic [2:0]    r_note_code, w_note_code_next;
   logic [CW-1:0] r_note_count, w_note_count_next;
   logic          w_key, w_full;
   logic [3:0]    w_note;

   // {valid, code} for the eight note keys A..K
   function automatic logic [3:0] f_note(input logic [7:0] b);
      case (b)
         8'h1C:   f_note = 4'b1_000;
         8'h1B:   f_note = 4'b1_001;
         8'h23:   f_note = 4'b1_010;
         8'h2B:   f_note = 4'b1_011;
         8'h34:   f_note = 4'b1_100;
         8'h33:   f_note = 4'b1_101;
         8'h3B:   f_note = 4'b1_110;
         8'h42:   f_note = 4'b1_111;
         default: f_note = 4'b0_000;
      endcase
   endfunction

   assign w_key  = bus.received_data_en && !r_brk &&
                   (bus.received_data != 8'hE0) && (bus.received_data != 8'hF0);
   assign w_note = f_note(bus.received_data);
   assign w_full = bus.is_full || (r_note_count == LP_MAX);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state      <= S_MENU;
         r_en         <= 9'd1;
         r_brk        <= 1'b0;
         r_note_code  <= 3'd0;
         r_note_count <= '0;
      end else begin
         r_state      <= w_next_state;
         r_en         <= w_en_next;
         r_brk        <= w_brk_next;
         r_note_code  <= w_note_code_next;
         r_note_count <= w_note_count_next;
      end
   end

   always_comb begin
      w_next_state      = r_state;
      w_note_code_next  = r_note_code;
      w_note_count_next = r_note_count;
      w_brk_next        = r_brk;
      // Break-code tracking runs in every state, busy ones included
      if (bus.received_data_en) begin
         if (bus.received_data == 8'hF0)      w_brk_next = 1'b1;
         else if (bus.received_data != 8'hE0) w_brk_next = 1'b0;
      end
      case (r_state)
         S_MENU:  if (w_key && bus.received_data == 8'h5A) w_next_state = S_LIST;
         S_LIST: begin
            if (w_key && bus.received_data == 8'h05) begin
               w_next_state      = S_SCORE;
               w_note_count_next = '0;
            end else if (w_key && bus.received_data == 8'h06) w_next_state = S_SONGS;
            else if (w_key && bus.received_data == 8'h76)      w_next_state = S_MENU;
         end
         S_SONGS: if (w_key && bus.received_data == 8'h76) w_next_state = S_LIST;
         S_SCORE: if (bus.score_drawn) w_next_state = S_NOTE_WAIT;
         S_NOTE_WAIT: begin
            if (w_key && w_note[3] && !w_full) begin
               w_next_state     = S_INSERT;
               w_note_code_next = w_note[2:0];
            end else if (w_key && bus.received_data == 8'h66 && r_note_count != '0)
               w_next_state = S_DELETE;
            else if (w_key && bus.received_data == 8'h29 && r_note_count != '0)
               w_next_state = S_PLAY;
            else if (w_key && bus.received_data == 8'h76)
               w_next_state = S_END;
         end
         S_INSERT: if (bus.insert_delay_done) begin
            w_next_state = S_NOTE_WAIT;
            if (r_note_count != LP_MAX) w_note_count_next = r_note_count + CW'(1);
         end
         S_DELETE: if (bus.insert_delay_done) begin
            w_next_state = S_NOTE_WAIT;
            if (r_note_count != '0) w_note_count_next = r_note_count - CW'(1);
         end
         S_PLAY:  if (bus.play_done) w_next_state = S_NOTE_WAIT;
         S_END: if (w_key && bus.received_data == 8'h5A) begin
            w_next_state      = S_MENU;
            w_note_count_next = '0;
         end
         default: w_next_state = S_MENU;
      endcase
   end

   // Enables are decoded from the next state so they register with it
   always_comb begin
      w_en_next = 9'd0;
      case (w_next_state)
         S_MENU:      w_en_next[0] = 1'b1;
         S_LIST:      w_en_next[1] = 1'b1;
         S_SONGS:     w_en_next[2] = 1'b1;
         S_SCORE:     w_en_next[3] = 1'b1;
         S_NOTE_WAIT: w_en_next[4] = 1'b1;
         S_INSERT:    w_en_next[5] = 1'b1;
         S_DELETE:    w_en_next[6] = 1'b1;
         S_PLAY:      w_en_next[7] = 1'b1;
         S_END:       w_en_next[8] = 1'b1;
         default:     w_en_next[0] = 1'b1;
      endcase
   end

   assign bus.menu_enable      = r_en[0];
   assign bus.list_enable      = r_en[1];
   assign bus.song_list_enable = r_en[2];
   assign bus.draw_score       = r_en[3];
   assign bus.note_enable      = r_en[4];
   assign bus.InsertEnable     = r_en[5];
   assign bus.deleteEnable     = r_en[6];
   assign bus.playEnable       = r_en[7];
   assign bus.end_vga_display  = r_en[8];
   assign bus.note_code        = r_note_code;
   assign bus.note_count       = r_note_count;
   assign bus.state            = r_state;
endmodule

// File: tb/tb_composer_control.sv
// Bench for composer_control: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_composer_control;
   logic clk;
   logic rst;
   int   n_tests, n_fail;

   composer_control_if #(.CW(5)) bus ();

   composer_control #(.MAX_NOTES(16), .CW(5)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: mode number, note count, selected note, break flag
   int   m_mode, m_cnt, m_code;
   bit   m_brk;
   byte  note_keys [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_code = 0; m_brk = 0;
   endtask

   task automatic model_step(input logic [7:0] d, input logic en, sd, fl, idd, pd);
      bit key;
      int ni;
      key = en && d != 8'hE0 && d != 8'hF0 && !m_brk;
      if (en && d == 8'hF0) m_brk = 1;
      else if (en && d != 8'hE0) m_brk = 0;
      ni = -1;
      foreach (note_keys[i]) if (note_keys[i] == d) ni = i;
      case (m_mode)
         0: if (key && d == 8'h5A) m_mode = 1;
         1: if (key && d == 8'h05) begin m_mode = 3; m_cnt = 0; end
            else if (key && d == 8'h06) m_mode = 2;
            else if (key && d == 8'h76) m_mode = 0;
         2: if (key && d == 8'h76) m_mode = 1;
         3: if (sd) m_mode = 4;
         4: if (key && ni >= 0) begin
               if (!(fl || m_cnt == 16)) begin m_mode = 5; m_code = ni; end
            end else if (key && d == 8'h66 && m_cnt > 0) m_mode = 6;
            else if (key && d == 8'h29 && m_cnt > 0) m_mode = 7;
            else if (key && d == 8'h76) m_mode = 8;
         5: if (idd) begin m_mode = 4; if (m_cnt < 16) m_cnt++; end
         6: if (idd) begin m_mode = 4; if (m_cnt > 0) m_cnt--; end
         7: if (pd) m_mode = 4;
         8: if (key && d == 8'h5A) begin m_mode = 0; m_cnt = 0; end
         default: m_mode = 0;
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dut_en();
      return {bus.end_vga_display, bus.playEnable, bus.InsertEnable == 1'b1 ? 1'b0 : 1'b0, 6'd0} == 0 ?
             int'({bus.end_vga_display, bus.playEnable, bus.deleteEnable, bus.InsertEnable,
                   bus.note_enable, bus.draw_score, bus.song_list_enable, bus.list_enable,
                   bus.menu_enable}) :
             int'({bus.end_vga_display, bus.playEnable, bus.deleteEnable, bus.InsertEnable,
                   bus.note_enable, bus.draw_score, bus.song_list_enable, bus.list_enable,
                   bus.menu_enable});
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".state"}, int'(bus.state), m_mode);
      check({tag, ".en"},    dut_en(), 1 << m_mode);
      check({tag, ".count"}, int'(bus.note_count), m_cnt);
      check({tag, ".code"},  int'(bus.note_code), m_code);
   endtask

   // Called at posedge+1: apply inputs, clock once, compare against the model
   task automatic drive(input logic [7:0] d, input logic en, sd, fl, idd, pd,
                        input string tag);
      bus.received_data     = d;
      bus.received_data_en  = en;
      bus.score_drawn       = sd;
      bus.is_full           = fl;
      bus.insert_delay_done = idd;
      bus.play_done         = pd;
      @(posedge clk);
      model_step(d, en, sd, fl, idd, pd);
      #1;
      check_model(tag);
   endtask

   task automatic key(input logic [7:0] d, input string tag);
      drive(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       en, sd, fl, idd, pd;
      int         rep, st, cnt, code;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [7:0] d, input logic en, sd, fl, idd, pd,
                      input int rep, st, cnt, code);
      vec_t v;
      v.d = d; v.en = en; v.sd = sd; v.fl = fl; v.idd = idd; v.pd = pd;
      v.rep = rep; v.st = st; v.cnt = cnt; v.code = code;
      tbl.push_back(v);
   endtask

   byte pool [18] = '{8'h5A, 8'h76, 8'h05, 8'h06, 8'h29, 8'h66, 8'h1C, 8'h1B, 8'h23,
                      8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'hF0, 8'hE0, 8'h12, 8'h00};

   initial begin
      n_tests = 0; n_fail = 0;
      bus.received_data = 8'h00; bus.received_data_en = 1'b0; bus.score_drawn = 1'b0;
      bus.is_full = 1'b0; bus.insert_delay_done = 1'b0; bus.play_done = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.state", int'(bus.state), 0);
      check("reset.en", dut_en(), 1);
      check("reset.count", int'(bus.note_count), 0);
      check("reset.code", int'(bus.note_code), 0);
      rst = 1'b0;

      //   data   en sd fl idd pd rep st cnt code
      add(8'h5A, 1, 0, 0, 0, 0, 1, 1, 0, 0);   // Enter -> LIST
      add(8'h05, 1, 0, 0, 0, 0, 1, 3, 0, 0);   // F1 -> SCORE
      add(8'h00, 0, 0, 0, 0, 0, 3, 3, 0, 0);   // still drawing
      add(8'h5A, 1, 0, 0, 0, 0, 1, 3, 0, 0);   // key dropped while busy
      add(8'h00, 0, 1, 0, 0, 0, 1, 4, 0, 0);   // score_drawn -> NOTE_WAIT
      add(8'h34, 1, 0, 0, 0, 0, 1, 5, 0, 4);   // 'G' -> INSERT, code 4
      add(8'h00, 0, 0, 0, 0, 0, 20, 5, 0, 4);  // InsertEnable held
      add(8'h00, 0, 0, 0, 1, 0, 1, 4, 1, 4);   // done -> count 1
      add(8'hF0, 1, 0, 0, 0, 0, 1, 4, 1, 4);
      add(8'h1C, 1, 0, 0, 0, 0, 1, 4, 1, 4);   // break code discarded
      add(8'hE0, 1, 0, 0, 0, 0, 1, 4, 1, 4);
      add(8'h1C, 1, 0, 0, 0, 0, 1, 5, 1, 0);   // extended prefix ignored
      add(8'h00, 0, 0, 0, 1, 0, 1, 4, 2, 0);
      add(8'h29, 1, 0, 0, 0, 0, 1, 7, 2, 0);   // Space -> PLAY
      add(8'h00, 0, 0, 0, 1, 0, 5, 7, 2, 0);   // wrong done ignored
      add(8'h00, 0, 0, 0, 0, 1, 1, 4, 2, 0);
      add(8'h66, 1, 0, 0, 0, 0, 1, 6, 2, 0);   // Backspace -> DELETE
      add(8'h00, 0, 0, 0, 1, 0, 1, 4, 1, 0);
      add(8'h1B, 1, 0, 1, 0, 0, 1, 4, 1, 0);   // is_full drops note key
      add(8'h76, 1, 0, 0, 0, 0, 1, 8, 1, 0);   // Esc -> END
      add(8'h5A, 1, 0, 0, 0, 0, 1, 0, 0, 0);   // Enter -> MENU, count cleared
      add(8'h5A, 1, 0, 0, 0, 0, 1, 1, 0, 0);
      add(8'h06, 1, 0, 0, 0, 0, 1, 2, 0, 0);   // F2 -> SONGS
      add(8'h76, 1, 0, 0, 0, 0, 1, 1, 0, 0);
      add(8'h76, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      add(8'h5A, 1, 0, 0, 0, 0, 1, 1, 0, 0);
      add(8'h05, 1, 0, 0, 0, 0, 1, 3, 0, 0);
      add(8'h00, 0, 1, 0, 0, 0, 1, 4, 0, 0);
      add(8'h66, 1, 0, 0, 0, 0, 1, 4, 0, 0);   // Backspace at 0 ignored
      add(8'h29, 1, 0, 0, 0, 0, 1, 4, 0, 0);   // Space at 0 ignored

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].rep; r++) begin
            drive(tbl[i].d, tbl[i].en, tbl[i].sd, tbl[i].fl, tbl[i].idd, tbl[i].pd, "vec");
            if (r == tbl[i].rep - 1) begin
               check($sformatf("vec%0d.state", i), int'(bus.state), tbl[i].st);
               check($sformatf("vec%0d.en", i), dut_en(), 1 << tbl[i].st);
               check($sformatf("vec%0d.count", i), int'(bus.note_count), tbl[i].cnt);
               check($sformatf("vec%0d.code", i), int'(bus.note_code), tbl[i].code);
            end
         end
      end

      // Fill to capacity, then a 17th note must be refused
      for (int i = 0; i < 16; i++) begin
         key(note_keys[i % 8], "fill.key");
         drive(8'h00, 0, 0, 0, 1, 0, "fill.done");
      end
      check("fill.count16", int'(bus.note_count), 16);
      key(8'h42, "full.key17");
      check("full.state", int'(bus.state), 4);
      check("full.code", int'(bus.note_code), 7);
      for (int i = 0; i < 13; i++) begin
         key(8'h66, "drain.key");
         drive(8'h00, 0, 0, 0, 1, 0, "drain.done");
      end
      check("drain.count3", int'(bus.note_count), 3);
      drive(8'h23, 1, 0, 1, 0, 0, "isfull.key");
      check("isfull.state", int'(bus.state), 4);

      // Asynchronous reset in the middle of PLAY
      key(8'h29, "play.start");
      repeat (3) drive(8'h00, 0, 0, 0, 0, 0, "play.hold");
      check("play.held", int'(bus.playEnable), 1);
      #2 rst = 1'b1;
      #1;
      check("areset.play", int'(bus.playEnable), 0);
      check("areset.menu", int'(bus.menu_enable), 1);
      check("areset.state", int'(bus.state), 0);
      check("areset.count", int'(bus.note_count), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [7:0] d;
         logic en, sd, fl, idd, pd;
         d   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 17)];
         en  = ($urandom_range(0, 3) != 0);
         sd  = ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 7) == 0);
         idd = ($urandom_range(0, 2) == 0);
         pd  = ($urandom_range(0, 3) == 0);
         drive(d, en, sd, fl, idd, pd, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/composer_control.md
# composer_control

Top-level sequencer for the composer. It consumes PS/2 scan bytes and the datapath's done/full status, and drives the datapath's one-hot mode enables. These enables cover menu, mode list, song list, blank-score draw, note entry, insert, delete, play-all and end screen. It also tracks the composition's note count and latches the note selected for insertion.

## Interface
- MAX_NOTES, 16, note capacity of one composition (4 bars × 4 quarter notes)
- CW, 5, width of note_count; must satisfy 2^CW > MAX_NOTES

- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; forces state MENU and all registers to reset values
- received_data  in  8  PS/2 scan byte from PS2_Controller
- received_data_en  in  1  one-cycle strobe, received_data valid
- score_drawn  in  1  blank score finished drawing
- is_full  in  1  datapath note storage full
- insert_delay_done  in  1  insert/delete settle delay elapsed
- play_done  in  1  play-all finished
- menu_enable, list_enable, song_list_enable, draw_score, note_enable, InsertEnable, deleteEnable, playEnable, end_vga_display  out  1 each  mode enables to datapath
- note_code  out  3  note to insert: 0..7 = C4..C5
- note_count  out  CW  notes currently in composition
- state  out  4  current state encoding, debug only

## Operation
- States: MENU=0, LIST=1, SONGS=2, SCORE=3, NOTE_WAIT=4, INSERT=5, DELETE=6, PLAY=7, END=8.
- Enable decoding (Moore, registered):
  - Exactly one enable is high per state: MENU→menu_enable, LIST→list_enable, SONGS→song_list_enable, SCORE→draw_score, NOTE_WAIT→note_enable, INSERT→InsertEnable, DELETE→deleteEnable, PLAY→playEnable, END→end_vga_display.
- Key decode:
  - A key event is a received_data_en byte that is not 0xE0 and not 0xF0, and is not the byte immediately following 0xF0.
  - Byte 0xF0 sets brk. The next strobed byte is discarded and clears brk.
  - 0xE0 is discarded and leaves brk unchanged.
- Commands: Enter=0x5A, Esc=0x76, F1=0x05, F2=0x06, Space=0x29, Backspace=0x66.
- Note keys: A,S,D,F,G,H,J,K = 0x1C,0x1B,0x23,0x2B,0x34,0x33,0x3B,0x42 → note_code 0..7.
- Transitions (key = key event this cycle):
  - MENU: Enter→LIST.
  - LIST: F1→SCORE (note_count←0); F2→SONGS; Esc→MENU.
  - SONGS: Esc→LIST.
  - SCORE: score_drawn→NOTE_WAIT.
  - NOTE_WAIT:
    - Note key and !full→INSERT, latch note_code.
    - Backspace and note_count>0→DELETE.
    - Space and note_count>0→PLAY.
    - Esc→END.
    - All other keys are ignored.
  - INSERT: insert_delay_done→NOTE_WAIT, note_count+1.
  - DELETE: insert_delay_done→NOTE_WAIT, note_count−1.
  - PLAY: play_done→NOTE_WAIT.
  - END: Enter→MENU (note_count←0).
  - Undefined encodings→MENU.
- full = is_full OR (note_count == MAX_NOTES). A note key while full is dropped and the state is unchanged.
- Busy states (SCORE, INSERT, DELETE, PLAY) drop all key events. The brk tracking still runs in these states.
- note_count saturates at 0 and MAX_NOTES; it never wraps. note_code holds its value until the next accepted note key.

## Timing
- Reset values: state=MENU, menu_enable=1, all other enables=0, note_code=0, note_count=0, brk=0.
- Accepted key on edge N: new state and enables are visible after edge N. Latency is 1 cycle.
- A done input sampled high on edge N: the enable drops and note_enable rises after edge N. note_count updates on that same edge.
- Done inputs are level-sensitive and sampled only in their owning state. A done input already high on entry completes after 1 cycle in that state.
- InsertEnable, deleteEnable and playEnable stay high continuously until their done input is seen, so the datapath delay counters run uninterrupted.
- Asserting reset mid-INSERT or mid-PLAY takes effect immediately (asynchronous). Enables drop without waiting for done.

## Test plan
- Reset then Enter (0x5A): menu_enable 1→0 and list_enable=1 one cycle after the strobe. Then F1: draw_score=1. Pulse score_drawn: note_enable=1, note_count=0.
- In NOTE_WAIT, send 0x34 ('G'): InsertEnable=1, note_code=4. Hold insert_delay_done low for 20 cycles: InsertEnable stays 1. Raise it: note_enable=1 next cycle, note_count=1.
- Break filtering: send 0xF0,0x1C: no state change. Send 0xE0,0x1C: INSERT with note_code=0.
- Insert 16 notes: note_count=16. A 17th note key: state stays NOTE_WAIT. Repeat at note_count=3 with is_full=1: key dropped.
- At note_count=0: Backspace and Space ignored. At note_count=2: Space→playEnable held until play_done→NOTE_WAIT. Backspace plus insert_delay_done→note_count=1.
- Esc→end_vga_display=1, then Enter→MENU with note_count=0. Assert reset during PLAY: playEnable=0 and menu_enable=1 with no clock edge.
